// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns a valid/ready command stream into zero-wait-state
// APB transfers (SETUP then ACCESS, no PREADY) and returns completions on a
// buffered valid/ready response stream. A command is only accepted when the
// response FIFO has a free slot reserved for it, so the FIFO cannot overflow.
module apb_master_bridge #(
  parameter int ADDR_WIDTH = 16,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  apb_pclk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [31:0]           rsp_rdata,
  output logic [31:0]           xfer_count,
  output logic [31:0]           apb_paddr,
  output logic                  apb_psel,
  output logic                  apb_penable,
  output logic                  apb_pwrite,
  output logic [31:0]           apb_pwdata,
  input  logic [31:0]           apb_prdata
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RSP_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W + 1)'(RSP_DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_nx_s;
  logic             psel_r;
  logic             penable_r;
  logic             pwrite_r;
  logic [31:0]      paddr_r;
  logic [31:0]      pwdata_r;
  logic [31:0]      xfer_count_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nx_s;
  logic             rsp_valid_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic             fifo_write_r [RSP_DEPTH];
  logic [31:0]      fifo_rdata_r [RSP_DEPTH];
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic             cmd_ready_s;
  logic [CNT_W:0]   occupancy_s;

  // Reservation check: FIFO entries plus the one in flight, less any pop now.
  always_comb begin
    occupancy_s = (CNT_W + 1)'(count_r);
    if (state_r != ST_IDLE) begin
      occupancy_s = occupancy_s + (CNT_W + 1)'(1);
    end else begin
      occupancy_s = occupancy_s;
    end
    if (pop_s) begin
      occupancy_s = occupancy_s - (CNT_W + 1)'(1);
    end else begin
      occupancy_s = occupancy_s;
    end
    if (rst) begin
      cmd_ready_s = 1'b0;
    end else if (((state_r == ST_IDLE) || (state_r == ST_ACCESS)) && (occupancy_s < DEPTH_LIM)) begin
      cmd_ready_s = 1'b1;
    end else begin
      cmd_ready_s = 1'b0;
    end
  end

  assign accept_s = cmd_valid && cmd_ready_s;
  assign push_s   = (state_r == ST_ACCESS);
  assign pop_s    = rsp_valid_r && rsp_ready;

  // Next FSM state: every transfer is exactly SETUP + ACCESS.
  always_comb begin
    state_nx_s = ST_IDLE;
    case (state_r)
      ST_IDLE:   state_nx_s = accept_s ? ST_SETUP : ST_IDLE;
      ST_SETUP:  state_nx_s = ST_ACCESS;
      ST_ACCESS: state_nx_s = accept_s ? ST_SETUP : ST_IDLE;
      default:   state_nx_s = ST_IDLE;
    endcase
  end

  // Next FIFO occupancy; a simultaneous push and pop cancels out.
  always_comb begin
    count_nx_s = count_r;
    if (push_s && !pop_s) begin
      count_nx_s = count_r + CNT_W'(1);
    end else if (pop_s && !push_s) begin
      count_nx_s = count_r - CNT_W'(1);
    end else begin
      count_nx_s = count_r;
    end
  end

  // FSM, APB control strobes and the transfer counter.
  always_ff @(posedge apb_pclk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      psel_r       <= 1'b0;
      penable_r    <= 1'b0;
      xfer_count_r <= 32'd0;
    end else begin
      state_r   <= state_nx_s;
      psel_r    <= (state_nx_s != ST_IDLE);
      penable_r <= (state_nx_s == ST_ACCESS);
      if (push_s) begin
        xfer_count_r <= xfer_count_r + 32'd1;
      end
    end
  end

  // Address/direction/data captured at accept and held until the next one.
  always_ff @(posedge apb_pclk) begin
    if (rst) begin
      paddr_r  <= 32'd0;
      pwrite_r <= 1'b0;
      pwdata_r <= 32'd0;
    end else if (accept_s) begin
      paddr_r  <= 32'(cmd_addr);
      pwrite_r <= cmd_write;
      pwdata_r <= cmd_wdata;
    end
  end

  // Response FIFO: pushed at the edge ending ACCESS, popped by the consumer.
  always_ff @(posedge apb_pclk) begin
    if (rst) begin
      count_r     <= '0;
      rsp_valid_r <= 1'b0;
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_write_r[i] <= 1'b0;
        fifo_rdata_r[i] <= 32'd0;
      end
    end else begin
      count_r     <= count_nx_s;
      rsp_valid_r <= (count_nx_s != '0);
      if (push_s) begin
        fifo_write_r[wr_ptr_r] <= pwrite_r;
        fifo_rdata_r[wr_ptr_r] <= pwrite_r ? 32'd0 : apb_prdata;
        wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? '0 : wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? '0 : rd_ptr_r + PTR_W'(1);
      end
    end
  end

  assign cmd_ready   = cmd_ready_s;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_write   = fifo_write_r[rd_ptr_r];
  assign rsp_rdata   = fifo_rdata_r[rd_ptr_r];
  assign xfer_count  = xfer_count_r;
  assign apb_paddr   = paddr_r;
  assign apb_psel    = psel_r;
  assign apb_penable = penable_r;
  assign apb_pwrite  = pwrite_r;
  assign apb_pwdata  = pwdata_r;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed testbench for apb_master_bridge with a behavioural APB memory.
module tb_apb_master_bridge;

  logic        apb_pclk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = 16'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [31:0] xfer_count;
  logic [31:0] apb_paddr;
  logic        apb_psel;
  logic        apb_penable;
  logic        apb_pwrite;
  logic [31:0] apb_pwdata;
  logic [31:0] apb_prdata;

  apb_master_bridge #(.ADDR_WIDTH(16), .RSP_DEPTH(2)) dut (
    .apb_pclk(apb_pclk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .xfer_count(xfer_count),
    .apb_paddr(apb_paddr), .apb_psel(apb_psel), .apb_penable(apb_penable),
    .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata)
  );

  always #5 apb_pclk = ~apb_pclk;

  // Behavioural zero-wait APB slave memory (64 words).
  logic [31:0] mem [64];
  assign apb_prdata = mem[apb_paddr[7:2]];
  always @(posedge apb_pclk) begin
    if (apb_psel && apb_penable && apb_pwrite) mem[apb_paddr[7:2]] <= apb_pwdata;
  end

  int checks = 0;
  int errors = 0;

  // Command table, driver state and response capture
  logic        c_wr [8];
  logic [15:0] c_addr [8];
  logic [31:0] c_data [8];
  int          n_cmd = 0;
  int          idx = 0;
  logic        acc_pending = 1'b0;
  logic        rst_nx = 1'b1;
  logic        rr_nx = 1'b0;
  logic [32:0] got_q [$];
  logic        log_psel [64];
  logic        log_pen [64];
  logic        log_pwrite [64];
  logic [31:0] log_paddr [64];
  logic [31:0] log_pwdata [64];
  int          lg = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_cmd(input logic w, input logic [15:0] a, input logic [31:0] d);
    c_wr[n_cmd] = w;
    c_addr[n_cmd] = a;
    c_data[n_cmd] = d;
    n_cmd++;
  endtask

  task automatic clear_all();
    n_cmd = 0;
    idx = 0;
    acc_pending = 1'b0;
    got_q.delete();
    lg = 0;
  endtask

  // One cycle: drive at negedge, then sample settled outputs 1 time unit later.
  task automatic step();
    @(negedge apb_pclk);
    rst = rst_nx;
    rsp_ready = rr_nx;
    if (acc_pending) idx++;
    acc_pending = 1'b0;
    if (idx < n_cmd) begin
      cmd_valid = 1'b1;
      cmd_write = c_wr[idx];
      cmd_addr = c_addr[idx];
      cmd_wdata = c_data[idx];
    end else begin
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr = 16'd0;
      cmd_wdata = 32'd0;
    end
    #1;
    acc_pending = cmd_valid && cmd_ready;
    if (!rst && rsp_valid && rsp_ready) got_q.push_back({rsp_write, rsp_rdata});
    if (lg < 64) begin
      log_psel[lg] = apb_psel;
      log_pen[lg] = apb_penable;
      log_pwrite[lg] = apb_pwrite;
      log_paddr[lg] = apb_paddr;
      log_pwdata[lg] = apb_pwdata;
      lg++;
    end
  endtask

  task automatic do_reset();
    clear_all();
    rst_nx = 1'b1;
    step();
    step();
    rst_nx = 1'b0;
    step();
    clear_all();
  endtask

  function automatic int first_psel();
    for (int i = 0; i < lg; i++) begin
      if (log_psel[i]) return i;
    end
    return -1;
  endfunction

  initial begin
    int f;
    logic [7:0] ps_vec;
    logic [7:0] pe_vec;
    logic found;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;

    // Reset: outputs all zero and cmd_ready low while rst is high
    rst_nx = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_psel", 64'(apb_psel), 64'd0);
    check("rst_penable", 64'(apb_penable), 64'd0);
    check("rst_pwrite", 64'(apb_pwrite), 64'd0);
    check("rst_paddr", 64'(apb_paddr), 64'd0);
    check("rst_pwdata", 64'(apb_pwdata), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_write", 64'(rsp_write), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_xfer_count", 64'(xfer_count), 64'd0);
    rst_nx = 1'b0;
    step();
    check("rel_cmd_ready", 64'(cmd_ready), 64'd1);
    clear_all();

    // Single write then read of the same address
    add_cmd(1'b1, 16'h0010, 32'hDEAD_BEEF);
    add_cmd(1'b0, 16'h0010, 32'h0);
    rr_nx = 1'b1;
    for (int i = 0; i < 12; i++) step();
    f = first_psel();
    check("wr_found_setup", 64'(f >= 0), 64'd1);
    if (f >= 0) begin
      check("wr_setup_pen", 64'(log_pen[f]), 64'd0);
      check("wr_setup_paddr", 64'(log_paddr[f]), 64'h0000_0010);
      check("wr_setup_pwdata", 64'(log_pwdata[f]), 64'hDEAD_BEEF);
      check("wr_setup_pwrite", 64'(log_pwrite[f]), 64'd1);
      check("wr_access_sel", 64'({log_psel[f+1], log_pen[f+1]}), 64'd3);
      check("wr_access_paddr", 64'(log_paddr[f+1]), 64'h0000_0010);
      check("wr_access_pwdata", 64'(log_pwdata[f+1]), 64'hDEAD_BEEF);
    end
    check("wr_rd_rsp_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() >= 2) begin
      check("wr_rsp", 64'(got_q[0]), 64'h1_0000_0000);
      check("rd_rsp", 64'(got_q[1]), 64'h0_DEAD_BEEF);
    end
    check("wr_rd_xfer_count", 64'(xfer_count), 64'd2);

    // Back-to-back writes with responses consumed immediately
    do_reset();
    for (int i = 0; i < 4; i++) add_cmd(1'b1, 16'(16'h0020 + 4 * i), 32'h1111_0000 + 32'(i));
    rr_nx = 1'b1;
    for (int i = 0; i < 14; i++) step();
    f = first_psel();
    check("b2b_found", 64'(f >= 0), 64'd1);
    if (f >= 0) begin
      for (int k = 0; k < 8; k++) begin
        ps_vec[k] = log_psel[f+k];
        pe_vec[k] = log_pen[f+k];
      end
      check("b2b_psel", 64'(ps_vec), 64'hFF);
      check("b2b_penable", 64'(pe_vec), 64'hAA);
      check("b2b_end_idle", 64'(log_psel[f+8]), 64'd0);
    end
    check("b2b_xfer_count", 64'(xfer_count), 64'd4);
    check("b2b_rsp_count", 64'(got_q.size()), 64'd4);

    // Backpressure: two reads fill the FIFO, the rest must wait
    do_reset();
    for (int i = 0; i < 4; i++) add_cmd(1'b0, 16'(16'h0020 + 4 * i), 32'h0);
    rr_nx = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("bp_xfer_count", 64'(xfer_count), 64'd2);
    check("bp_accepted", 64'(idx), 64'd2);
    check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    check("bp_psel", 64'(apb_psel), 64'd0);
    check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    check("bp_rsp_head", 64'(rsp_rdata), 64'h1111_0000);
    rr_nx = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check("bp_rsp_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      check($sformatf("bp_rsp%0d", i), 64'(got_q[i]), 64'h1111_0000 + 64'(i));
    end
    check("bp_xfer_final", 64'(xfer_count), 64'd4);

    // Reset during the ACCESS phase of a read
    do_reset();
    add_cmd(1'b0, 16'h0020, 32'h0);
    rr_nx = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (log_psel[lg-1] && !log_pen[lg-1]) found = 1'b1;
    end
    check("rm_saw_setup", 64'(found), 64'd1);
    rst_nx = 1'b1;
    step();
    check("rm_in_access", 64'(apb_penable), 64'd1);
    rst_nx = 1'b0;
    step();
    check("rm_psel", 64'(apb_psel), 64'd0);
    check("rm_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rm_xfer_count", 64'(xfer_count), 64'd0);
    for (int i = 0; i < 6; i++) step();
    check("rm_no_stale_rsp", 64'(got_q.size()), 64'd0);
    check("rm_xfer_after", 64'(xfer_count), 64'd0);

    // Counter wrap from all-ones
    clear_all();
    force dut.xfer_count_r = 32'hFFFF_FFFF;
    step();
    release dut.xfer_count_r;
    step();
    add_cmd(1'b1, 16'h0030, 32'h0000_0005);
    for (int i = 0; i < 8; i++) step();
    check("wrap_rsp_count", 64'(got_q.size()), 64'd1);
    check("wrap_xfer_count", 64'(xfer_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
